branch_resolve_ctrl: RTL and testbench

// Tracks in-flight predicted branches from fetch to resolution in the JB (jump/branch) stage.

---
 rtl/branch_resolve_ctrl_pkg.sv | 29 ++
 rtl/branch_resolve_ctrl_if.sv | 46 ++++
 rtl/branch_resolve_ctrl_pred_fifo.sv | 71 +++++++
 rtl/branch_resolve_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for branch tracking/resolution.
// Entry layout, FSM states and BHT counter encodings.
package branch_resolve_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } pred_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  function automatic logic [XLEN-1:0] seq_pc(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Fetch / JB / BHT signal bundle.
// master drives fetch and resolve, slave is the controller.
interface branch_resolve_ctrl_if #(
  parameter int DEPTH       = 4,
  parameter int TABLE_WIDTH = 3
);
  import branch_resolve_ctrl_pkg::*;

  logic                     fe_push_valid;
  logic                     fe_push_ready;
  logic [XLEN-1:0]          fe_pc;
  logic                     fe_pred_taken;
  logic [XLEN-1:0]          fe_pred_target;
  logic                     ex_resolve_valid;
  logic                     ex_taken;
  logic [XLEN-1:0]          ex_target;
  logic                     flush;
  logic [XLEN-1:0]          redirect_pc;
  logic [TABLE_WIDTH-1:0]   JB_PC_Slice;
  logic                     JB_AttemptBranch;
  logic                     JB_BranchTaken;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [31:0]              mispredict_cnt;
  logic                     underflow_err;

  modport master (
    output fe_push_valid, fe_pc, fe_pred_taken,
    output fe_pred_target, ex_resolve_valid,
    output ex_taken, ex_target,
    input  fe_push_ready, flush, redirect_pc,
    input  JB_PC_Slice, JB_AttemptBranch,
    input  JB_BranchTaken, occupancy,
    input  mispredict_cnt, underflow_err
  );

  modport slave (
    input  fe_push_valid, fe_pc, fe_pred_taken,
    input  fe_pred_target, ex_resolve_valid,
    input  ex_taken, ex_target,
    output fe_push_ready, flush, redirect_pc,
    output JB_PC_Slice, JB_AttemptBranch,
    output JB_BranchTaken, occupancy,
    output mispredict_cnt, underflow_err
  );

endinterface

// File: rtl/branch_resolve_ctrl_pred_fifo.sv
// In-order FIFO of predicted branches.
// Clear wins over push/pop; caller never pushes full or pops empty.
module branch_resolve_ctrl_pred_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  pred_entry_t            wdata_i,
  output pred_entry_t            head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  pred_entry_t   mem_q [DEPTH];

  // next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // pointer/occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: in-flight tracking,
// mispredict flush/redirect and one BHT update per branch.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TABLE_WIDTH = 3
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_ctrl_if.slave bus
);

  ctrl_state_e            state_q;
  logic                   flush_q;
  logic [XLEN-1:0]        redirect_q;
  logic [31:0]            mcnt_q;
  logic                   attempt_q;
  logic [TABLE_WIDTH-1:0] slice_q;
  logic                   taken_q;
  logic                   under_q;

  pred_entry_t            head;
  pred_entry_t            wdata;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   ready;
  logic                   push_ok;
  logic                   res_ok;
  logic                   mispredict;

  assign wdata.pc          = bus.fe_pc;
  assign wdata.pred_taken  = bus.fe_pred_taken;
  assign wdata.pred_target = bus.fe_pred_target;

  assign ready   = (state_q == RUN) && !full;
  assign push_ok = bus.fe_push_valid && ready;
  assign res_ok  = bus.ex_resolve_valid
                && (state_q == RUN) && !empty;

  assign mispredict = res_ok
    && ((bus.ex_taken != head.pred_taken)
     || (bus.ex_taken
      && (bus.ex_target != head.pred_target)));

  // everything in flight is younger than a mispredict
  branch_resolve_ctrl_pred_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok && !mispredict),
    .pop_i   (res_ok && !mispredict),
    .clear_i (mispredict),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // RUN/FLUSH FSM with registered flush/redirect/count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      mcnt_q     <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mispredict) begin
            state_q    <= FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= bus.ex_taken ? bus.ex_target
                                       : seq_pc(head.pc);
            if (mcnt_q != '1) mcnt_q <= mcnt_q + 32'd1;
          end else begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
          end
        end
        FLUSH: begin
          state_q    <= RUN;
          flush_q    <= 1'b0;
          redirect_q <= '0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // BHT update strobe and sticky underflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempt_q <= 1'b0;
      slice_q   <= '0;
      taken_q   <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      attempt_q <= res_ok;
      if (res_ok) begin
        slice_q <= head.pc[TABLE_WIDTH+1:2];
        taken_q <= bus.ex_taken;
      end
      if (bus.ex_resolve_valid && (state_q == RUN) && empty)
        under_q <= 1'b1;
    end
  end

  assign bus.fe_push_ready    = ready;
  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.JB_PC_Slice      = slice_q;
  assign bus.JB_AttemptBranch = attempt_q;
  assign bus.JB_BranchTaken   = taken_q;
  assign bus.occupancy        = count;
  assign bus.mispredict_cnt   = mcnt_q;
  assign bus.underflow_err    = under_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: reference FIFO model
// plus update/redirect scoreboards.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if bus ();

  branch_resolve_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0] slice;
    logic       taken;
  } upd_t;

  upd_t        upd_q [$];
  logic [31:0] redir_q [$];
  pred_entry_t mq [$];
  bit          m_flush;
  bit          m_under;
  logic [31:0] m_cnt;
  int          checks;
  int          errors;

  task automatic model_reset();
    mq.delete();
    upd_q.delete();
    redir_q.delete();
    m_flush = 0;
    m_under = 0;
    m_cnt   = '0;
  endtask

  task automatic cyc();
    upd_t u;
    logic [31:0] r;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (upd_q.size() != 0) begin
      u = upd_q.pop_front();
      if (bus.JB_AttemptBranch !== 1'b1
          || bus.JB_PC_Slice !== u.slice
          || bus.JB_BranchTaken !== u.taken) begin
        errors++;
        $display("FAIL update: got att=%b slice=%0d tk=%b want att=1 slice=%0d tk=%b",
                 bus.JB_AttemptBranch, bus.JB_PC_Slice,
                 bus.JB_BranchTaken, u.slice, u.taken);
      end
    end else if (bus.JB_AttemptBranch !== 1'b0) begin
      errors++;
      $display("FAIL spurious_update: got att=%b want 0",
               bus.JB_AttemptBranch);
    end
    checks++;
    if (redir_q.size() != 0) begin
      r = redir_q.pop_front();
      if (bus.flush !== 1'b1 || bus.redirect_pc !== r) begin
        errors++;
        $display("FAIL flush: got flush=%b pc=%h want flush=1 pc=%h",
                 bus.flush, bus.redirect_pc, r);
      end
    end else if (bus.flush !== 1'b0) begin
      errors++;
      $display("FAIL spurious_flush: got flush=%b want 0", bus.flush);
    end
  endtask

  task automatic drive(
    input bit pv, input logic [31:0] pc, input bit pt,
    input logic [31:0] ptgt, input bit rv, input bit et,
    input logic [31:0] etgt
  );
    bit ready;
    bit mis;
    pred_entry_t h;
    pred_entry_t e;
    ready = !m_flush && (mq.size() < 4);
    checks++;
    if (bus.fe_push_ready !== ready) begin
      errors++;
      $display("FAIL push_ready: got %b want %b",
               bus.fe_push_ready, ready);
    end
    bus.fe_push_valid    = pv;
    bus.fe_pc            = pc;
    bus.fe_pred_taken    = pt;
    bus.fe_pred_target   = ptgt;
    bus.ex_resolve_valid = rv;
    bus.ex_taken         = et;
    bus.ex_target        = etgt;
    e.pc          = pc;
    e.pred_taken  = pt;
    e.pred_target = ptgt;
    mis = 0;
    if (rv && !m_flush) begin
      if (mq.size() == 0) m_under = 1;
      else begin
        h = mq[0];
        mis = (et != h.pred_taken)
           || (et && (etgt != h.pred_target));
        upd_q.push_back('{slice: h.pc[4:2], taken: et});
        if (mis) begin
          redir_q.push_back(et ? etgt : h.pc + 32'd4);
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
          mq.delete();
        end else begin
          void'(mq.pop_front());
        end
      end
    end
    if (pv && ready && !mis) mq.push_back(e);
    m_flush = mis;
    cyc();
    bus.fe_push_valid    = 1'b0;
    bus.ex_resolve_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 3'(mq.size())
        || bus.underflow_err !== m_under
        || bus.mispredict_cnt !== m_cnt) begin
      errors++;
      $display("FAIL state: got occ=%0d und=%b cnt=%0d want occ=%0d und=%b cnt=%0d",
               bus.occupancy, bus.underflow_err,
               bus.mispredict_cnt, mq.size(), m_under, m_cnt);
    end
  endtask

  task automatic push(input logic [31:0] pc, input bit pt,
                      input logic [31:0] ptgt);
    drive(1, pc, pt, ptgt, 0, 0, '0);
  endtask

  task automatic resolve(input bit et, input logic [31:0] etgt);
    drive(0, '0, 0, '0, 1, et, etgt);
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0 || bus.redirect_pc !== '0) begin
      errors++;
      $display("FAIL reset_flush: got %b/%h want 0/0",
               bus.flush, bus.redirect_pc);
    end
    checks++;
    if (bus.JB_AttemptBranch !== 1'b0 || bus.JB_PC_Slice !== '0
        || bus.JB_BranchTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_jb: got %b/%0d/%b want 0/0/0",
               bus.JB_AttemptBranch, bus.JB_PC_Slice,
               bus.JB_BranchTaken);
    end
    checks++;
    if (bus.occupancy !== '0 || bus.mispredict_cnt !== '0
        || bus.underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%b want 0/0/0",
               bus.occupancy, bus.mispredict_cnt,
               bus.underflow_err);
    end
    checks++;
    if (bus.fe_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.fe_push_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_correct();
    push(32'h100, 0, '0);
    resolve(0, '0);
    idle();
  endtask

  task automatic test_dir_mispredict();
    push(32'h104, 0, '0);
    push(32'h108, 0, '0);
    push(32'h10C, 0, '0);
    resolve(1, 32'h200);
    checks++;
    if (bus.fe_push_ready !== 1'b0 || bus.occupancy !== '0) begin
      errors++;
      $display("FAIL flush_cycle: got rdy=%b occ=%0d want 0/0",
               bus.fe_push_ready, bus.occupancy);
    end
    drive(1, 32'h500, 0, '0, 1, 1, '0);
    checks++;
    if (bus.fe_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_flush_ready: got %b want 1",
               bus.fe_push_ready);
    end
  endtask

  task automatic test_target_mispredict();
    push(32'h120, 1, 32'h300);
    resolve(1, 32'h340);
    idle();
    push(32'h1FC, 1, 32'h400);
    resolve(0, '0);
    idle();
    push(32'h130, 0, '0);
    drive(1, 32'h140, 0, '0, 1, 1, 32'h600);
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      push(32'h200 + 32'(i * 4), 0, '0);
    checks++;
    if (bus.fe_push_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL full: got rdy=%b occ=%0d want 0/4",
               bus.fe_push_ready, bus.occupancy);
    end
    push(32'h210, 0, '0);
    drive(1, 32'h214, 0, '0, 1, 0, '0);
    resolve(0, '0);
    drive(1, 32'h218, 0, '0, 1, 0, '0);
    checks++;
    if (bus.occupancy !== 3'd2) begin
      errors++;
      $display("FAIL simul: got occ=%0d want 2", bus.occupancy);
    end
    resolve(0, '0);
    resolve(0, '0);
  endtask

  task automatic test_underflow_reset();
    resolve(1, 32'h10);
    checks++;
    if (bus.underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got %b want 1", bus.underflow_err);
    end
    push(32'h300, 0, '0);
    push(32'h304, 1, 32'h80);
    push(32'h308, 0, '0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.occupancy !== '0 || bus.flush !== 1'b0
        || bus.JB_AttemptBranch !== 1'b0
        || bus.underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d fl=%b att=%b und=%b want 0",
               bus.occupancy, bus.flush, bus.JB_AttemptBranch,
               bus.underflow_err);
    end
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0 || bus.JB_AttemptBranch !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: got fl=%b att=%b want 0/0",
               bus.flush, bus.JB_AttemptBranch);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    logic [31:0] pt_tgt;
    logic [31:0] ex_tgt;
    for (int i = 0; i < 300; i++) begin
      pc     = 32'h1000 + ($urandom_range(0, 63) << 2);
      pt_tgt = $urandom_range(0, 1) ? 32'h40 : 32'h80;
      ex_tgt = $urandom_range(0, 1) ? 32'h40 : 32'h80;
      drive($urandom_range(0, 1), pc, $urandom_range(0, 1),
            pt_tgt, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1), ex_tgt);
    end
    idle();
    idle();
    checks++;
    if (upd_q.size() != 0 || redir_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending upd=%0d redir=%0d want 0/0",
               upd_q.size(), redir_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.fe_push_valid    = 1'b0;
    bus.fe_pc            = '0;
    bus.fe_pred_taken    = 1'b0;
    bus.fe_pred_target   = '0;
    bus.ex_resolve_valid = 1'b0;
    bus.ex_taken         = 1'b0;
    bus.ex_target        = '0;
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_target_mispredict();
    test_full();
    test_underflow_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
